// File: rtl/aes_output_buffer.sv
// aes_output_buffer: circular buffer of decrypted 128-bit AES blocks,
// replayed to a 32-bit valid/ready consumer most-significant word first.
// is_full is the backpressure to the decryption pipeline. It is decoded only
// from the registered count, so no combinational path leads from data_done
// or out_ready to is_full.
module aes_output_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic [127:0]             data_in,
  input  logic                     data_done,
  input  logic                     clear,
  output logic                     is_full,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [$clog2(DEPTH):0]   block_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Block storage. Stored contents are never reset. They are only visible
  // while count is nonzero.
  logic [127:0]  mem [DEPTH];

  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic [1:0]    word_idx_reg, word_idx_next;

  logic          capture;
  logic          transfer;
  logic          release_blk;
  logic [127:0]  rd_entry;
  logic [31:0]   rd_words [4];

  assign is_full     = (count_reg == CW'(DEPTH));
  assign out_valid   = (count_reg != '0);
  // A block held by the pipeline while we are full stays on data_in.
  // It is taken on the first edge after is_full drops.
  assign capture     = data_done & ~is_full & ~clear;
  assign transfer    = out_valid & out_ready;
  assign release_blk = transfer & (word_idx_reg == 2'd3);

  assign rd_entry = mem[rd_ptr_reg];

  // Word 0 is the most significant 32 bits of the block.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_word
      assign rd_words[gi] = rd_entry[127-32*gi -: 32];
    end
  endgenerate

  assign out_data    = out_valid ? rd_words[word_idx_reg] : 32'h0;
  assign out_last    = out_valid & (word_idx_reg == 2'd3);
  assign block_count = count_reg;

  // Write the captured block into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  // Next-state for pointers, count and word index. Clear overrides everything.
  always_comb begin
    wr_ptr_next   = wr_ptr_reg;
    rd_ptr_next   = rd_ptr_reg;
    count_next    = count_reg;
    word_idx_next = word_idx_reg;
    if (clear) begin
      wr_ptr_next   = '0;
      rd_ptr_next   = '0;
      count_next    = '0;
      word_idx_next = '0;
    end else begin
      if (capture) begin
        wr_ptr_next = wr_ptr_reg + PW'(1);
      end
      if (transfer) begin
        word_idx_next = word_idx_reg + 2'd1;
      end
      if (release_blk) begin
        rd_ptr_next = rd_ptr_reg + PW'(1);
      end
      // A simultaneous capture and release leaves the count unchanged.
      case ({capture, release_blk})
        2'b10:   count_next = count_reg + CW'(1);
        2'b01:   count_next = count_reg - CW'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  // State registers. Reset is asynchronous and active-low.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      word_idx_reg <= '0;
    end else begin
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      word_idx_reg <= word_idx_next;
    end
  end

endmodule

// File: tb/tb_aes_output_buffer.sv
// Testbench for aes_output_buffer. The reference model is a queue of stored
// blocks plus the index of the word currently presented.
// The source side is a queue of pending blocks. The head of that queue is held
// on data_in with data_done asserted until it is captured.
module tb_aes_output_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [127:0]  data_in = '0;
  logic          data_done = 1'b0;
  logic          clear = 1'b0;
  logic          out_ready = 1'b0;
  logic          is_full;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_last;
  logic [CW-1:0] block_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] mq[$];    // model: blocks stored in the buffer, oldest first
  int           widx = 0; // model: word of the head block being presented
  logic [127:0] srcq[$];  // pending blocks from the pipeline

  aes_output_buffer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .data_in     (data_in),
    .data_done   (data_done),
    .clear       (clear),
    .is_full     (is_full),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .block_count (block_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [31:0] word_of(logic [127:0] b, int w);
    return b[127-32*w -: 32];
  endfunction

  // Expected {out_valid, out_last, is_full, block_count, out_data}, taken from the model.
  function automatic logic [CW+34:0] exp_vec();
    logic [31:0] d;
    d = (mq.size() != 0) ? word_of(mq[0], widx) : 32'h0;
    return {mq.size() != 0, (mq.size() != 0) && (widx == 3), mq.size() == DEPTH,
            CW'(mq.size()), d};
  endfunction

  function automatic logic [CW+34:0] obs_vec();
    return {out_valid, out_last, is_full, block_count, out_data};
  endfunction

  task automatic drive_src();
    data_done = (srcq.size() != 0);
    if (srcq.size() != 0) data_in = srcq[0];
  endtask

  // Apply one clock edge to the model and to the DUT. Return at the following negedge.
  task automatic tick();
    bit full;
    full = (mq.size() == DEPTH);
    if (!n_rst || clear) begin
      mq.delete();
      widx = 0;
    end else begin
      if (mq.size() != 0 && out_ready) begin
        if (widx == 3) begin
          mq.delete(0);
          widx = 0;
        end else begin
          widx++;
        end
      end
      if (data_done && !full) begin
        mq.push_back(data_in);
        if (srcq.size() != 0) srcq.delete(0);
      end
    end
    @(posedge clk);
    @(negedge clk);
    drive_src();
  endtask

  task automatic test_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_cmp++; if (out_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", out_last); end
    n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", out_data); end
    n_cmp++; if (is_full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", is_full); end
    n_cmp++; if (block_count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", block_count); end
    $display("test_reset done");
  endtask

  task automatic test_single_block();
    logic [31:0] w[4];
    w[0] = 32'h00112233; w[1] = 32'h44556677; w[2] = 32'h8899AABB; w[3] = 32'hCCDDEEFF;
    out_ready = 1'b1;
    srcq.push_back(128'h00112233_44556677_8899AABB_CCDDEEFF);
    drive_src();
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== w[i] || out_last !== (i == 3)) begin
        n_err++;
        $display("FAIL single_word%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b",
                 i, out_valid, out_data, out_last, w[i], (i == 3));
      end
      tick();
    end
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 32'h0) begin
      n_err++; $display("FAIL single_empty: got v=%b d=%h want v=0 d=0", out_valid, out_data);
    end
    $display("test_single_block done");
  endtask

  task automatic test_fill();
    logic [127:0] b5;
    logic [31:0]  got[$];
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) srcq.push_back(rnd128());
    b5 = srcq[4];
    drive_src();
    repeat (4) tick();
    n_cmp++; if (is_full !== 1'b1) begin n_err++; $display("FAIL fill_full: got %b want 1", is_full); end
    n_cmp++; if (block_count !== CW'(4)) begin n_err++; $display("FAIL fill_count: got %0d want 4", block_count); end
    repeat (3) tick();
    n_cmp++; if (block_count !== CW'(4)) begin n_err++; $display("FAIL fill_hold: got %0d want 4", block_count); end
    out_ready = 1'b1;
    for (int c = 0; c < 60 && (srcq.size() != 0 || mq.size() != 0); c++) begin
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL fill_model c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
    end
    n_cmp++;
    if (got.size() != 20 || {got[16], got[17], got[18], got[19]} !== b5) begin
      n_err++; $display("FAIL fill_block5: got %0d words, want 20 ending %h", got.size(), b5);
    end
    $display("test_fill done");
  endtask

  task automatic test_stall();
    bit          pat[6];
    logic [31:0] prev;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    out_ready = 1'b0;
    srcq.push_back(rnd128());
    drive_src();
    tick();
    prev = out_data;
    for (int c = 0; c < 6; c++) begin
      out_ready = pat[c];
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL stall_model c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (c > 0 && !pat[c-1]) begin
        n_cmp++;
        if (out_data !== prev) begin
          n_err++; $display("FAIL stall_stable c%0d: got %h want %h", c, out_data, prev);
        end
      end
      prev = out_data;
      tick();
    end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_end: got %b want 0", out_valid); end
    $display("test_stall done");
  endtask

  task automatic test_wrap();
    logic [31:0] exp_w[$];
    logic [31:0] got[$];
    for (int i = 0; i < 10; i++) begin
      srcq.push_back(rnd128());
      for (int w = 0; w < 4; w++) exp_w.push_back(word_of(srcq[i], w));
    end
    drive_src();
    for (int c = 0; c < 400 && (srcq.size() != 0 || mq.size() != 0); c++) begin
      out_ready = 1'($urandom_range(0, 1));
      n_cmp++;
      if (obs_vec() !== exp_vec() || block_count > CW'(DEPTH)) begin
        n_err++; $display("FAIL wrap_model c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (out_valid && out_ready) got.push_back(out_data);
      tick();
    end
    n_cmp++;
    if (srcq.size() != 0 || mq.size() != 0) begin
      n_err++; $display("FAIL wrap_timeout: got %0d blocks left want 0", srcq.size() + mq.size());
    end
    n_cmp++;
    if (got != exp_w) begin
      n_err++; $display("FAIL wrap_order: got %0d words want %0d in input order", got.size(), exp_w.size());
    end
    $display("test_wrap done");
  endtask

  task automatic test_simultaneous();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) srcq.push_back(rnd128());
    drive_src();
    repeat (4) tick();
    out_ready = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (out_last !== 1'b1 || is_full !== 1'b1 || data_done !== 1'b1) begin
      n_err++; $display("FAIL simul_setup: got last=%b full=%b want 1 1", out_last, is_full);
    end
    tick();
    n_cmp++; if (block_count !== CW'(3)) begin n_err++; $display("FAIL simul_count3: got %0d want 3", block_count); end
    n_cmp++; if (is_full !== 1'b0) begin n_err++; $display("FAIL simul_notfull: got %b want 0", is_full); end
    tick();
    n_cmp++; if (block_count !== CW'(4)) begin n_err++; $display("FAIL simul_count4: got %0d want 4", block_count); end
    for (int c = 0; c < 60 && (srcq.size() != 0 || mq.size() != 0); c++) begin
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL simul_model c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    $display("test_simultaneous done");
  endtask

  task automatic test_clear();
    logic [127:0] b3;
    out_ready = 1'b0;
    srcq.push_back(rnd128());
    srcq.push_back(rnd128());
    drive_src();
    repeat (2) tick();
    out_ready = 1'b1;
    repeat (2) tick();
    b3 = rnd128();
    srcq.push_back(b3);
    drive_src();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || block_count !== '0) begin
      n_err++; $display("FAIL clear_empty: got v=%b cnt=%0d want v=0 cnt=0", out_valid, block_count);
    end
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== b3[127:96] || out_last !== 1'b0) begin
      n_err++; $display("FAIL clear_next: got %h want %h", out_data, b3[127:96]);
    end
    for (int c = 0; c < 30 && (srcq.size() != 0 || mq.size() != 0); c++) begin
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL clear_model c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    $display("test_clear done");
  endtask

  task automatic test_reset_mid_block();
    logic [127:0] bn;
    out_ready = 1'b1;
    srcq.push_back(rnd128());
    drive_src();
    repeat (3) tick();
    n_rst = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || block_count !== '0 || out_data !== 32'h0 || out_last !== 1'b0) begin
      n_err++; $display("FAIL rstmid_async: got v=%b cnt=%0d d=%h want 0 0 0", out_valid, block_count, out_data);
    end
    mq.delete();
    widx = 0;
    srcq.delete();
    data_done = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    bn = rnd128();
    srcq.push_back(bn);
    drive_src();
    tick();
    n_cmp++;
    if (out_valid !== 1'b1 || out_data !== bn[127:96]) begin
      n_err++; $display("FAIL rstmid_word0: got %h want %h", out_data, bn[127:96]);
    end
    for (int c = 0; c < 30 && (srcq.size() != 0 || mq.size() != 0); c++) begin
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_err++; $display("FAIL rstmid_model c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    $display("test_reset_mid_block done");
  endtask

  initial begin
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    n_rst = 1'b1;
    @(negedge clk);
    test_single_block();
    test_fill();
    test_stall();
    test_wrap();
    test_simultaneous();
    test_clear();
    test_reset_mid_block();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
